// File: rtl/midi_pkg.sv
// Shared MIDI constants, event codes and encoder FSM states.
// Also holds the status-byte builder used by the transmit encoder.
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_POLY_AT  = 4'hA;
  localparam logic [3:0] MIDI_PITCH    = 4'hE;

  typedef enum logic [1:0] {
    EVT_NOTE_OFF = 2'd0,
    EVT_NOTE_ON  = 2'd1,
    EVT_POLY_AT  = 2'd2,
    EVT_PITCH    = 2'd3
  } evt_type_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STATUS = 2'd1,
    DATA1  = 2'd2,
    DATA2  = 2'd3
  } tx_state_t;

  // Note-off may be folded onto the note-on status so it can share running status.
  function automatic logic [7:0] status_byte(input evt_type_t t, input logic [3:0] ch,
                                             input logic zero_vel);
    logic [3:0] nib;
    unique case (t)
      EVT_NOTE_OFF: nib = zero_vel ? MIDI_NOTE_ON : MIDI_NOTE_OFF;
      EVT_NOTE_ON:  nib = MIDI_NOTE_ON;
      EVT_POLY_AT:  nib = MIDI_POLY_AT;
      default:      nib = MIDI_PITCH;
    endcase
    return {nib, ch};
  endfunction

endpackage

// File: rtl/midi_tx_encoder_if.sv
// Event-request and UART byte-handshake bundle for the MIDI transmit encoder.
// master = event source / UART side, slave = encoder.
interface midi_tx_encoder_if;
  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_type;
  logic [3:0]  channel;
  logic [6:0]  note;
  logic [6:0]  velocity;
  logic [13:0] bend;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output evt_valid, evt_type, channel, note, velocity, bend, tx_ready,
    input  evt_ready, tx_data, tx_valid
  );

  modport slave (
    input  evt_valid, evt_type, channel, note, velocity, bend, tx_ready,
    output evt_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/midi_rs_timer.sv
// Running-status window: opens when a status byte is sent, closes RS_TIMEOUT cycles later.
// expire flags the closing cycle so acceptance logic can let expiry win.
module midi_rs_timer #(
  parameter int RS_TIMEOUT = 28_800_000
) (
  input  logic clk96,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic open,
  output logic expire
);

  localparam int CNT_W = (RS_TIMEOUT > 1) ? $clog2(RS_TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt;

  assign expire = open && (cnt == CNT_W'(RS_TIMEOUT - 1));

  always_ff @(posedge clk96) begin
    if (rst) begin
      open <= 1'b0;
      cnt  <= '0;
    end else if (clear) begin
      open <= enable;
      cnt  <= '0;
    end else if (expire) begin
      open <= 1'b0;
      cnt  <= '0;
    end else if (open) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/midi_tx_encoder.sv
// Serialises note/controller events into MIDI status + data bytes for the UART,
// with optional running-status compression.
module midi_tx_encoder
  import midi_pkg::*;
#(
  parameter bit RUNNING_STATUS       = 1'b1,
  parameter int RS_TIMEOUT           = 28_800_000,
  parameter bit NOTE_OFF_AS_ZERO_VEL = 1'b0
) (
  input  logic               clk96,
  input  logic               rst,
  midi_tx_encoder_if.slave   link
);

  tx_state_t   state, next_state;
  logic [7:0]  tx_data_r, next_tx_data;
  logic        tx_valid_r, next_tx_valid;
  logic        accept, rs_clear;
  logic        rs_open, rs_expire, rs_live;
  logic [7:0]  last_status;
  logic [7:0]  evt_status;

  evt_type_t   type_q;
  logic [6:0]  note_q;
  logic [6:0]  vel_q;
  logic [13:0] bend_q;
  logic [7:0]  status_q;
  logic [7:0]  data1_byte, data2_byte;

  assign link.evt_ready = (state == IDLE) && !rst;
  assign link.tx_data   = tx_data_r;
  assign link.tx_valid  = tx_valid_r;

  assign evt_status = status_byte(evt_type_t'(link.evt_type), link.channel, NOTE_OFF_AS_ZERO_VEL);
  assign rs_live    = rs_open && !rs_expire;

  assign data1_byte = (type_q == EVT_PITCH) ? {1'b0, bend_q[6:0]} : {1'b0, note_q};

  always_comb begin
    data2_byte = {1'b0, vel_q};
    if (type_q == EVT_PITCH)
      data2_byte = {1'b0, bend_q[13:7]};
    else if (type_q == EVT_NOTE_OFF && NOTE_OFF_AS_ZERO_VEL)
      data2_byte = 8'h00;
  end

  midi_rs_timer #(.RS_TIMEOUT(RS_TIMEOUT)) u_rs_timer (
    .clk96  (clk96),
    .rst    (rst),
    .clear  (rs_clear),
    .enable (RUNNING_STATUS),
    .open   (rs_open),
    .expire (rs_expire)
  );

  // A state first presents its byte; on transfer it advances and presents the next one.
  always_comb begin
    next_state    = state;
    next_tx_data  = tx_data_r;
    next_tx_valid = tx_valid_r;
    accept        = 1'b0;
    rs_clear      = 1'b0;
    unique case (state)
      IDLE: begin
        if (link.evt_valid) begin
          accept = 1'b1;
          if (RUNNING_STATUS && rs_live && evt_status == last_status)
            next_state = DATA1;
          else
            next_state = STATUS;
        end
      end
      STATUS: begin
        if (!tx_valid_r) begin
          next_tx_valid = 1'b1;
          next_tx_data  = status_q;
        end else if (link.tx_ready) begin
          rs_clear     = 1'b1;
          next_state   = DATA1;
          next_tx_data = data1_byte;
        end
      end
      DATA1: begin
        if (!tx_valid_r) begin
          next_tx_valid = 1'b1;
          next_tx_data  = data1_byte;
        end else if (link.tx_ready) begin
          next_state   = DATA2;
          next_tx_data = data2_byte;
        end
      end
      default: begin
        if (!tx_valid_r) begin
          next_tx_valid = 1'b1;
          next_tx_data  = data2_byte;
        end else if (link.tx_ready) begin
          next_state    = IDLE;
          next_tx_valid = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk96) begin
    if (rst) begin
      state       <= IDLE;
      tx_valid_r  <= 1'b0;
      tx_data_r   <= 8'h00;
      last_status <= 8'h00;
    end else begin
      state      <= next_state;
      tx_valid_r <= next_tx_valid;
      tx_data_r  <= next_tx_data;
      if (rs_clear)
        last_status <= status_q;
    end
  end

  always_ff @(posedge clk96) begin
    if (accept) begin
      type_q   <= evt_type_t'(link.evt_type);
      note_q   <= link.note;
      vel_q    <= link.velocity;
      bend_q   <= link.bend;
      status_q <= evt_status;
    end
  end

endmodule

// File: tb/tb_midi_tx_encoder.sv
// Scoreboard bench for midi_tx_encoder: directed events push expected bytes,
// per-instance monitors pop and compare on every UART transfer.
module tb_midi_tx_encoder;

  logic clk96 = 1'b0;
  always #5 clk96 = ~clk96;

  logic rst_a, rst_b;
  midi_tx_encoder_if a ();
  midi_tx_encoder_if b ();

  midi_tx_encoder #(.RUNNING_STATUS(1'b1), .RS_TIMEOUT(16), .NOTE_OFF_AS_ZERO_VEL(1'b0)) dut_a (
    .clk96 (clk96),
    .rst   (rst_a),
    .link  (a)
  );

  midi_tx_encoder #(.RUNNING_STATUS(1'b1), .RS_TIMEOUT(16), .NOTE_OFF_AS_ZERO_VEL(1'b1)) dut_b (
    .clk96 (clk96),
    .rst   (rst_b),
    .link  (b)
  );

  int passed = 0;
  int total  = 0;
  int xfer_a = 0;
  int xfer_b = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  always @(negedge clk96) begin
    if (!rst_a && a.tx_valid === 1'b1 && a.tx_ready === 1'b1) begin
      xfer_a++;
      if (exp_a.size() == 0) check("a_unexpected_byte", {8'h00, a.tx_data}, 16'hFFFF);
      else check("a_byte", {8'h00, a.tx_data}, {8'h00, exp_a.pop_front()});
    end
    if (!rst_b && b.tx_valid === 1'b1 && b.tx_ready === 1'b1) begin
      xfer_b++;
      if (exp_b.size() == 0) check("b_unexpected_byte", {8'h00, b.tx_data}, 16'hFFFF);
      else check("b_byte", {8'h00, b.tx_data}, {8'h00, exp_b.pop_front()});
    end
  end

  task automatic push3(input bit sel, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    if (!sel) begin exp_a.push_back(b0); exp_a.push_back(b1); exp_a.push_back(b2); end
    else begin exp_b.push_back(b0); exp_b.push_back(b1); exp_b.push_back(b2); end
  endtask

  task automatic push2(input bit sel, input logic [7:0] b1, input logic [7:0] b2);
    if (!sel) begin exp_a.push_back(b1); exp_a.push_back(b2); end
    else begin exp_b.push_back(b1); exp_b.push_back(b2); end
  endtask

  // Returns at accept-edge + 1; fields are scrambled afterwards to prove they were latched.
  task automatic send(input bit sel, input logic [1:0] t, input logic [3:0] ch,
                      input logic [6:0] n, input logic [6:0] v, input logic [13:0] bd);
    bit got = 1'b0;
    if (!sel) begin
      a.evt_type = t; a.channel = ch; a.note = n; a.velocity = v; a.bend = bd; a.evt_valid = 1'b1;
    end else begin
      b.evt_type = t; b.channel = ch; b.note = n; b.velocity = v; b.bend = bd; b.evt_valid = 1'b1;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk96);
      got = sel ? b.evt_ready : a.evt_ready;
    end
    @(posedge clk96); #1;
    if (!sel) begin
      a.evt_valid = 1'b0; a.evt_type = ~t; a.channel = ~ch; a.note = ~n; a.velocity = ~v; a.bend = ~bd;
    end else begin
      b.evt_valid = 1'b0; b.evt_type = ~t; b.channel = ~ch; b.note = ~n; b.velocity = ~v; b.bend = ~bd;
    end
    if (!got) check("send_accept_timeout", 16'd0, 16'd1);
  endtask

  task automatic wait_done(input bit sel);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk96);
      if (!sel) done = (exp_a.size() == 0) && !a.tx_valid;
      else      done = (exp_b.size() == 0) && !b.tx_valid;
    end
    if (!done) check("message_done_timeout", 16'd0, 16'd1);
    @(posedge clk96); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk96);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected summary earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    rst_a = 1'b1; rst_b = 1'b1;
    a.evt_valid = 1'b0; a.evt_type = '0; a.channel = '0; a.note = '0; a.velocity = '0; a.bend = '0;
    b.evt_valid = 1'b0; b.evt_type = '0; b.channel = '0; b.note = '0; b.velocity = '0; b.bend = '0;
    a.tx_ready = 1'b1; b.tx_ready = 1'b1;
    idle(3);

    // Reset state
    check("rst_evt_ready_low", {15'd0, a.evt_ready}, 16'd0);
    check("rst_tx_valid", {15'd0, a.tx_valid}, 16'd0);
    check("rst_tx_data", {8'd0, a.tx_data}, 16'h0000);
    check("rst_b_tx_valid", {15'd0, b.tx_valid}, 16'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    check("post_rst_evt_ready", {15'd0, a.evt_ready}, 16'd1);
    idle(2);

    // 1: note-on with latency and evt_ready profile
    push3(0, 8'h93, 8'h3C, 8'h64);
    send(0, 2'd1, 4'd3, 7'd60, 7'd100, 14'd0);
    check("t1_valid_at_N", {15'd0, a.tx_valid}, 16'd0);
    check("t1_ready_at_N", {15'd0, a.evt_ready}, 16'd0);
    idle(1);
    check("t1_valid_at_N1", {15'd0, a.tx_valid}, 16'd1);
    check("t1_data_at_N1", {8'd0, a.tx_data}, 16'h0093);
    check("t1_ready_at_N1", {15'd0, a.evt_ready}, 16'd0);
    idle(1);
    check("t1_ready_at_N2", {15'd0, a.evt_ready}, 16'd0);
    idle(1);
    check("t1_ready_at_N3", {15'd0, a.evt_ready}, 16'd0);
    idle(1);
    check("t1_ready_at_N4", {15'd0, a.evt_ready}, 16'd1);
    check("t1_valid_at_N4", {15'd0, a.tx_valid}, 16'd0);

    // 2: running status inside the window, full message after it closes
    idle(4);
    push2(0, 8'h3C, 8'h64);
    send(0, 2'd1, 4'd3, 7'd60, 7'd100, 14'd0);
    wait_done(0);
    idle(20);
    push3(0, 8'h93, 8'h3C, 8'h64);
    send(0, 2'd1, 4'd3, 7'd60, 7'd100, 14'd0);
    wait_done(0);

    // 3: pitch wheel
    push3(0, 8'hE0, 8'h00, 8'h40);
    send(0, 2'd3, 4'd0, 7'd0, 7'd0, 14'h2000);
    wait_done(0);
    push2(0, 8'h7F, 8'h7F);
    send(0, 2'd3, 4'd0, 7'd0, 7'd0, 14'h3FFF);
    wait_done(0);
    idle(20);
    push3(0, 8'hE0, 8'h7F, 8'h7F);
    send(0, 2'd3, 4'd0, 7'd0, 7'd0, 14'h3FFF);
    wait_done(0);

    // 4: UART stall on the first data byte
    idle(20);
    x0 = xfer_a;
    push3(0, 8'h95, 8'h10, 8'h20);
    send(0, 2'd1, 4'd5, 7'h10, 7'h20, 14'd0);
    idle(2);
    a.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk96);
      check("t4_stall_valid", {15'd0, a.tx_valid}, 16'd1);
      check("t4_stall_data", {8'd0, a.tx_data}, 16'h0010);
    end
    @(posedge clk96); #1;
    a.tx_ready = 1'b1;
    wait_done(0);
    check("t4_byte_count", 16'(xfer_a - x0), 16'd3);

    // 5: note-off, both encodings
    idle(20);
    push3(0, 8'h83, 8'h3C, 8'h40);
    send(0, 2'd0, 4'd3, 7'd60, 7'd64, 14'd0);
    wait_done(0);
    push3(1, 8'h93, 8'h3C, 8'h64);
    send(1, 2'd1, 4'd3, 7'd60, 7'd100, 14'd0);
    wait_done(1);
    push2(1, 8'h3C, 8'h00);
    send(1, 2'd0, 4'd3, 7'd60, 7'd64, 14'd0);
    wait_done(1);

    // 6: reset after the status byte aborts the message and closes the window
    idle(20);
    x0 = xfer_a;
    exp_a.push_back(8'h93);
    send(0, 2'd1, 4'd3, 7'd60, 7'd100, 14'd0);
    idle(2);
    rst_a = 1'b1;
    @(negedge clk96);
    check("t6_ready_in_rst", {15'd0, a.evt_ready}, 16'd0);
    @(posedge clk96); #1;
    check("t6_valid_after_rst", {15'd0, a.tx_valid}, 16'd0);
    check("t6_data_after_rst", {8'd0, a.tx_data}, 16'h0000);
    rst_a = 1'b0;
    idle(3);
    check("t6_bytes_before_abort", 16'(xfer_a - x0), 16'd1);
    check("t6_queue_empty", 16'(exp_a.size()), 16'd0);
    push3(0, 8'h93, 8'h3C, 8'h64);
    send(0, 2'd1, 4'd3, 7'd60, 7'd100, 14'd0);
    wait_done(0);

    check("final_queue_a", 16'(exp_a.size()), 16'd0);
    check("final_queue_b", 16'(exp_b.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
